// File: rtl/song_recorder.sv
// song_recorder: records key hits, one bit per beat, into three note lanes
// (red, yellow, blue) for the playback shifter. MSB holds the first beat.
// A take is LEAD_IN forced-silent beats followed by live capture until
// SONG_LEN beats have been shifted.
// Optional build macro SONG_RECORDER_EDGE_EN: when defined, each key is
// rising-edge detected, so a held key marks only the beat it was pressed in.
module song_recorder #(
  parameter int SONG_LEN = 100,
  parameter int LEAD_IN  = 13
) (
  input  logic                clock,
  input  logic                reset_b,
  input  logic                beat_tick,
  input  logic                start,
  input  logic [2:0]          keys,
  output logic                recording,
  output logic                done,
  output logic [6:0]          beat_count,
  output logic [SONG_LEN-1:0] red_seq,
  output logic [SONG_LEN-1:0] yellow_seq,
  output logic [SONG_LEN-1:0] blue_seq
);

  typedef enum logic [1:0] {IDLE, LEAD, REC, DONE} state_t;

  // A zero-length lead-in goes straight to capture.
  localparam state_t FIRST = (LEAD_IN == 0) ? REC : LEAD;

  state_t                     state_q, state_d;
  logic [6:0]                 cnt_q, cnt_d;
  logic [2:0][SONG_LEN-1:0]   lane_q, lane_d;   // [2]=red [1]=yellow [0]=blue
  logic [2:0]                 latch_q, latch_d;
  logic [2:0]                 key_eff;
  logic [2:0]                 hit;
  logic [6:0]                 cnt_inc;

`ifdef SONG_RECORDER_EDGE_EN
  logic [2:0] prev_q, prev_d;

  // Key history only tracks while capturing, so a key already held when
  // capture begins still counts once.
  always_comb begin
    prev_d = '0;
    if (state_q == REC && !start) prev_d = keys;
  end

  // Edge-detector history register.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) prev_q <= '0;
    else          prev_q <= prev_d;
  end

  assign key_eff = keys & ~prev_q;
`else
  assign key_eff = keys;
`endif

  // A press coincident with the closing tick still belongs to that beat.
  assign hit     = latch_q | key_eff;
  assign cnt_inc = cnt_q + 7'd1;

  // Next-state logic: start overrides everything, including a same-cycle tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lane_d  = lane_q;
    latch_d = latch_q;
    if (start) begin
      state_d = FIRST;
      cnt_d   = '0;
      lane_d  = '0;
      latch_d = '0;
    end else begin
      unique case (state_q)
        LEAD: begin
          latch_d = '0;
          if (beat_tick) begin
            for (int i = 0; i < 3; i++)
              lane_d[i] = {lane_q[i][SONG_LEN-2:0], 1'b0};
            cnt_d = cnt_inc;
            if (cnt_inc == 7'(LEAD_IN)) state_d = REC;
          end
        end
        REC: begin
          if (beat_tick) begin
            for (int i = 0; i < 3; i++)
              lane_d[i] = {lane_q[i][SONG_LEN-2:0], hit[i]};
            latch_d = '0;
            cnt_d   = cnt_inc;
            if (cnt_inc == 7'(SONG_LEN)) state_d = DONE;
          end else begin
            latch_d = hit;
          end
        end
        default: ;  // IDLE and DONE hold everything until start
      endcase
    end
  end

  // State, counter, latch and lane registers.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lane_q  <= '0;
      latch_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lane_q  <= lane_d;
      latch_q <= latch_d;
    end
  end

  assign recording  = (state_q == LEAD) || (state_q == REC);
  assign done       = (state_q == DONE);
  assign beat_count = cnt_q;
  assign red_seq    = lane_q[2];
  assign yellow_seq = lane_q[1];
  assign blue_seq   = lane_q[0];

endmodule

// File: tb/tb_song_recorder.sv
// Scoreboard bench for song_recorder: a small DUT (8 beats, 2 lead-in) and a
// default-sized DUT (100/13) share one input stream. A beat-list reference
// model predicts every cycle; a negedge monitor pops and compares.
module tb_song_recorder;

  logic         clock = 1'b0;
  logic         reset_b = 1'b0;
  logic         beat_tick = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   keys = 3'b000;

  logic         rec_a, done_a, rec_b, done_b;
  logic [6:0]   cnt_a, cnt_b;
  logic [7:0]   r_a, y_a, b_a;
  logic [99:0]  r_b, y_b, b_b;

  song_recorder #(.SONG_LEN(8), .LEAD_IN(2)) dut_a (
    .clock(clock), .reset_b(reset_b), .beat_tick(beat_tick), .start(start),
    .keys(keys), .recording(rec_a), .done(done_a), .beat_count(cnt_a),
    .red_seq(r_a), .yellow_seq(y_a), .blue_seq(b_a));

  song_recorder dut_b (
    .clock(clock), .reset_b(reset_b), .beat_tick(beat_tick), .start(start),
    .keys(keys), .recording(rec_b), .done(done_b), .beat_count(cnt_b),
    .red_seq(r_b), .yellow_seq(y_b), .blue_seq(b_b));

  always #5 clock = ~clock;

  typedef struct {
    bit         rec;
    bit         dn;
    bit [6:0]   cnt;
    bit [127:0] r, y, b;
  } obs_t;

  int vectors = 0;
  int miscompares = 0;
  obs_t qa[$];
  obs_t qb[$];

  // Reference model: a take is a list of beats, each beat a 3-bit hit set.
  int       n[2];
  int       ph[2];        // 0 idle, 1 taking, 2 finished
  bit [2:0] lat[2];
  bit [2:0] prv[2];
  bit [2:0] hist[2][128];

  function automatic int sl(int d); return (d == 0) ? 8 : 100; endfunction
  function automatic int li(int d); return (d == 0) ? 2 : 13;  endfunction

  function automatic void model_step(int d, bit rb, bit st, bit tk, bit [2:0] ks);
    bit [2:0] eff;
    if (!rb || st) begin
      ph[d] = rb ? 1 : 0; n[d] = 0; lat[d] = 0; prv[d] = 0;
    end else if (ph[d] == 1) begin
      if (n[d] < li(d)) begin
        prv[d] = 0;
        if (tk) begin hist[d][n[d]] = 3'b000; n[d]++; end
      end else begin
`ifdef SONG_RECORDER_EDGE_EN
        eff = ks & ~prv[d];
`else
        eff = ks;
`endif
        prv[d] = ks;
        if (tk) begin
          hist[d][n[d]] = lat[d] | eff;
          lat[d] = 0;
          n[d]++;
          if (n[d] == sl(d)) ph[d] = 2;
        end else begin
          lat[d] = lat[d] | eff;
        end
      end
    end
  endfunction

  // Beat k of n sits at bit n-1-k (newest beat at the LSB).
  function automatic obs_t expect_of(int d);
    obs_t o;
    o.rec = (ph[d] == 1); o.dn = (ph[d] == 2); o.cnt = 7'(n[d]);
    o.r = '0; o.y = '0; o.b = '0;
    for (int k = 0; k < n[d]; k++) begin
      o.r[n[d]-1-k] = hist[d][k][2];
      o.y[n[d]-1-k] = hist[d][k][1];
      o.b[n[d]-1-k] = hist[d][k][0];
    end
    return o;
  endfunction

  function automatic obs_t obs_a();
    obs_t o;
    o.rec = rec_a; o.dn = done_a; o.cnt = cnt_a;
    o.r = 128'(r_a); o.y = 128'(y_a); o.b = 128'(b_a);
    return o;
  endfunction

  function automatic obs_t obs_b();
    obs_t o;
    o.rec = rec_b; o.dn = done_b; o.cnt = cnt_b;
    o.r = 128'(r_b); o.y = 128'(y_b); o.b = 128'(b_b);
    return o;
  endfunction

  task automatic chk(string nm, bit [127:0] act, bit [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic cmp_obs(string tag, obs_t a, obs_t e);
    chk({tag, ".recording"},  128'(a.rec), 128'(e.rec));
    chk({tag, ".done"},       128'(a.dn),  128'(e.dn));
    chk({tag, ".beat_count"}, 128'(a.cnt), 128'(e.cnt));
    chk({tag, ".red_seq"},    a.r, e.r);
    chk({tag, ".yellow_seq"}, a.y, e.y);
    chk({tag, ".blue_seq"},   a.b, e.b);
  endtask

  // Monitor: the DUT presents its state every cycle; compare at negedge.
  always @(negedge clock) begin
    if (qa.size() != 0 && qb.size() != 0) begin
      obs_t ea, eb;
      ea = qa.pop_front();
      eb = qb.pop_front();
      cmp_obs("A", obs_a(), ea);
      cmp_obs("B", obs_b(), eb);
    end
  end

  // One clock of stimulus; the model advances with the same inputs.
  task automatic step(bit st, bit tk, bit [2:0] ks);
    start = st; beat_tick = tk; keys = ks;
    @(posedge clock);
    for (int d = 0; d < 2; d++) model_step(d, reset_b, st, tk, ks);
    qa.push_back(expect_of(0));
    qb.push_back(expect_of(1));
    #1;
  endtask

  initial begin
    bit [2:0] k;
    obs_t z;
    for (int d = 0; d < 2; d++) model_step(d, 1'b0, 1'b0, 1'b0, 3'b000);
    qa.push_back(expect_of(0));
    qb.push_back(expect_of(1));
    #12 reset_b = 1'b1;

    // Basic take on the 8/2 instance.
    step(1, 0, 3'b000);
    for (int t = 1; t <= 8; t++) begin
      step(0, 0, (t == 3) ? 3'b100 : 3'b000);
      step(0, 1, (t == 8) ? 3'b001 : 3'b000);
    end
    chk("basic.red",    128'(r_a), 128'(8'b00100000));
    chk("basic.blue",   128'(b_a), 128'(8'b00000001));
    chk("basic.yellow", 128'(y_a), 128'(0));
    chk("basic.done",   128'(done_a), 128'(1));
    chk("basic.count",  128'(cnt_a), 128'(8));

    // Ticks and keys after done must not disturb the take.
    for (int t = 0; t < 6; t++) step(0, t[0], 3'b111);
    chk("hold.red",  128'(r_a), 128'(8'b00100000));
    chk("hold.done", 128'(done_a), 128'(1));

    // Held yellow key across capture beats 3..5.
    step(1, 0, 3'b000);
    for (int t = 1; t <= 8; t++) begin
      k = (t >= 3 && t <= 5) ? 3'b010 : 3'b000;
      step(0, 0, k);
      step(0, 1, k);
    end
`ifdef SONG_RECORDER_EDGE_EN
    chk("held.yellow", 128'(y_a), 128'(8'b00100000));
`else
    chk("held.yellow", 128'(y_a), 128'(8'b00111000));
`endif

    // Lead-in masking on the default instance.
    step(1, 0, 3'b000);
    for (int t = 1; t <= 100; t++) begin
      k = (t <= 13) ? 3'b111 : 3'b000;
      step(0, 0, k);
      step(0, 1, k);
      if (t == 99) chk("lead.done_early", 128'(done_b), 128'(0));
    end
    chk("lead.done", 128'(done_b), 128'(1));
    chk("lead.red",  128'(r_b), 128'(0));
    chk("lead.yel",  128'(y_b), 128'(0));
    chk("lead.blue", 128'(b_b), 128'(0));

    // Restart coincident with tick 5, then a full take.
    step(1, 0, 3'b000);
    for (int t = 1; t <= 4; t++) step(0, 1, 3'b101);
    step(1, 1, 3'b000);
    chk("restart.count", 128'(cnt_b), 128'(0));
    chk("restart.rec",   128'(rec_b), 128'(1));
    for (int t = 1; t <= 100; t++) begin
      step(0, 1, 3'($urandom));
      if (t == 99) chk("restart.done_early", 128'(done_b), 128'(0));
    end
    chk("restart.done", 128'(done_b), 128'(1));

    // Asynchronous reset mid-capture with non-zero lanes.
    step(1, 0, 3'b000);
    for (int t = 1; t <= 5; t++) step(0, 1, 3'b111);
    #5;
    reset_b = 1'b0;
    #1;
    z.rec = 0; z.dn = 0; z.cnt = 0; z.r = '0; z.y = '0; z.b = '0;
    cmp_obs("async_rst_A", obs_a(), z);
    cmp_obs("async_rst_B", obs_b(), z);
    step(0, 0, 3'b000);
    reset_b = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      bit st, tk;
      st = ($urandom_range(0, 299) == 0);
      tk = ($urandom_range(0, 2) == 0);
      k  = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      step(st, tk, k);
    end

    start = 0; beat_tick = 0; keys = 0;
    for (int i = 0; i < 10 && qa.size() != 0; i++) @(negedge clock);
    #1;
    if (qa.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", qa.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
